// File: rtl/seq_det_pkg.sv
// Shared types for the time-shared "001" detector scheduler.
package seq_det_pkg;
    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} det_state_e;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, SAVE} sched_state_e;
    localparam int CNT_W = 8;
endpackage

// File: rtl/seq_det_core.sv
// Combinational "001" detector step, shared by every lane through the scheduler.
module seq_det_core
    import seq_det_pkg::*;
(
    input  det_state_e state_i,
    input  logic       bit_i,
    output det_state_e next_o,
    output logic       hit_o
);
    always_comb begin
        next_o = S0;
        hit_o  = 1'b0;
        case (state_i)
            S0: next_o = bit_i ? S0 : S1;
            S1: next_o = bit_i ? S0 : S2;
            S2: begin
                next_o = bit_i ? S0 : S2;
                hit_o  = bit_i;
            end
            default: next_o = S0;
        endcase
    end
endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one "001" detector across LANES serial lanes.
// Optional per-lane saturating detect counters: define SEQ_SCHED_CNT_EN.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int WINDOW = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           req,
    input  logic [LANES-1:0]           inp,
    output logic [LANES-1:0]           gnt,
    output logic                       det,
    output logic [$clog2(LANES)-1:0]   det_lane,
    output logic                       busy
`ifdef SEQ_SCHED_CNT_EN
    ,
    input  logic [$clog2(LANES)-1:0]   cnt_sel,
    output logic [CNT_W-1:0]           cnt_out
`endif
);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(WINDOW + 1);

    sched_state_e   state_q;
    logic [LW-1:0]  cur_q, last_q, base, pick;
    det_state_e     ctx_q [LANES];
    det_state_e     work_q, work_d;
    logic [CW-1:0]  wcnt_q;
    logic [LANES-1:0] gnt_q;
    logic           det_q, busy_q, hit;
    logic [LW-1:0]  det_lane_q;

    seq_det_core u_core (
        .state_i(work_q),
        .bit_i  (inp[cur_q]),
        .next_o (work_d),
        .hit_o  (hit)
    );

    // In SAVE the lane being retired becomes "last" this edge, so search from it.
    // Scanning from the far end lets the nearest requester win; base itself is last resort.
    always_comb begin
        base = (state_q == SAVE) ? cur_q : last_q;
        pick = base;
        for (int k = LANES; k >= 1; k--) begin
            if (req[(int'(base) + k) % LANES]) pick = LW'((int'(base) + k) % LANES);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            last_q     <= LW'(LANES - 1);
            work_q     <= S0;
            wcnt_q     <= '0;
            for (int i = 0; i < LANES; i++) ctx_q[i] <= S0;
            gnt_q      <= '0;
            det_q      <= 1'b0;
            det_lane_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            det_q <= 1'b0;
            case (state_q)
                IDLE: if (|req) begin
                    cur_q   <= pick;
                    state_q <= LOAD;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    work_q  <= ctx_q[cur_q];
                    wcnt_q  <= '0;
                    gnt_q   <= LANES'(1) << cur_q;
                    state_q <= RUN;
                end
                RUN: if (req[cur_q]) begin
                    work_q <= work_d;
                    wcnt_q <= wcnt_q + 1'b1;
                    if (hit) begin
                        det_q      <= 1'b1;
                        det_lane_q <= cur_q;
                    end
                    if (wcnt_q == CW'(WINDOW - 1)) begin
                        gnt_q   <= '0;
                        state_q <= SAVE;
                    end
                end else begin
                    gnt_q   <= '0;
                    state_q <= SAVE;
                end
                SAVE: begin
                    ctx_q[cur_q] <= work_q;
                    last_q       <= cur_q;
                    if (|req) begin
                        cur_q   <= pick;
                        state_q <= LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign det      = det_q;
    assign det_lane = det_lane_q;
    assign busy     = busy_q;

`ifdef SEQ_SCHED_CNT_EN
    logic [CNT_W-1:0] dcnt_q [LANES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) dcnt_q[i] <= '0;
        end else if (det_q && (dcnt_q[det_lane_q] != '1)) begin
            dcnt_q[det_lane_q] <= dcnt_q[det_lane_q] + 1'b1;
        end
    end

    assign cnt_out = dcnt_q[cnt_sel];
`endif
endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that time-shares one "001" serial pattern-detector core among LANES serial input lanes. Each requesting lane is granted a window of up to WINDOW bits. The per-lane detector state is saved and restored around every window, so a pattern that straddles two windows of the same lane is still detected. It sits between the lane serializers and the interrupt/status logic, replacing one detector per lane.

## Interface
- LANES, 4: number of serial lanes (≥2)
- WINDOW, 4: max bits consumed per grant (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  LANES  per-lane "bit available"; lane i presents its bit on inp[i] while req[i]=1
- inp  in  LANES  per-lane serial data bit
- gnt  out  LANES  one-hot grant; bit consumed on an edge where gnt[i]&req[i]
- det  out  1  one-cycle pulse: "001" completed on lane det_lane
- det_lane  out  $clog2(LANES)  lane index qualifying det
- busy  out  1  high in any state other than IDLE

## Operation
- Detector state per lane, 2 bits: S0 (no prefix), S1 ("0"), S2 ("00"). Transitions: S0 -0-> S1, S0 -1-> S0; S1 -0-> S2, S1 -1-> S0; S2 -0-> S2, S2 -1-> S0 with detect. Overlapping matching.
- Context array ctx[LANES] holds the saved detector state; a working register holds the active lane's state.
- FSM states:
  - IDLE: if any req, pick the lane by round-robin → LOAD; else stay.
  - LOAD: working state ← ctx[cur]; window counter ← 0 → RUN.
  - RUN: gnt[cur]=1. If req[cur]=1: consume inp[cur], update working state, and increment the counter. Go to SAVE when req[cur]=0 (no bit consumed this cycle) or when the consumed bit is the WINDOW-th.
  - SAVE: ctx[cur] ← working state; last ← cur; if any req, pick next → LOAD, else → IDLE.
- Round robin: search starts at last+1 modulo LANES. A lane that just finished is eligible again only if no other lane requests.
- gnt is zero outside RUN and never has more than one bit set.
- det/det_lane are registered. Each is high the cycle after the consuming edge of the '1' that completes "001".

## Timing
- Reset (rst=0, asynchronous): gnt=0, det=0, det_lane=0, busy=0, FSM=IDLE, all ctx=S0, last=LANES-1 (so lane 0 is served first).
- Slot overhead: 1 IDLE arbitration cycle (only from IDLE), then LOAD 1 cycle, RUN 1..WINDOW cycles, SAVE 1 cycle. Back-to-back slots: SAVE→LOAD, with no IDLE cycle.
- Detect latency: 1 cycle after the consuming edge.
- req dropping mid-RUN: slot ends with no penalty; the partial context is saved.
- req dropping during LOAD: RUN sees req=0, goes to SAVE, and ctx is unchanged.
- Reset mid-RUN: the pending det is lost and all contexts are cleared.
- Counter width $clog2(WINDOW+1); the counter never wraps, because the window ends at WINDOW.

## Configuration
- SEQ_SCHED_CNT_EN defined: adds per-lane 8-bit saturating detection counters. Each counter increments with det on det_lane and holds at 255.
  - Added ports: cnt_sel in $clog2(LANES) and cnt_out out 8. cnt_out = counter[cnt_sel], combinational read.
  - Counters reset to 0.
- SEQ_SCHED_CNT_EN undefined: no counters, no extra ports, no other behaviour change.

## Structure
- Package seq_det_pkg holds:
  - detector state enum (S0,S1,S2)
  - scheduler state enum (IDLE,LOAD,RUN,SAVE)
  - counter width constant CNT_W=8
- Sub-module seq_det_core is combinational: (state, bit) → (next_state, hit). It is instantiated once and shared by all lanes.

## Test plan
- Single lane: reset, req=0001, lane 0 bits 0,0,1 → det=1 and det_lane=0, one cycle after the edge consuming the '1'. gnt=0001 only in RUN.
- Straddle, WINDOW=2: lane 0 sends 0,0 in slot 1 and 1 in slot 2 → det in slot 2, proving the ctx save/restore.
- Round robin: req=1111 held, all inputs 0 → grant order 0,1,2,3,0. Each RUN lasts exactly WINDOW cycles with SAVE→LOAD back-to-back. No det.
- Early drop: req[1] falls on the 2nd RUN cycle → SAVE next cycle, the partial state is kept, then lane 2 is granted.
- Reset mid-RUN: rst=0 asynchronously while ctx[0]=S2 → outputs go to 0 immediately. After release, bit 1 on lane 0 gives no det.
- With SEQ_SCHED_CNT_EN: 300 detections on lane 3 → cnt_out=255 with cnt_sel=3, and cnt_out=0 with cnt_sel=0.
